// File: rtl/cevero_dvfs_actuator_if.sv
// Regulator and PLL handshake bundle driven by the DVFS actuator.
// master: the actuator side; slave: the regulator/PLL side.
interface cevero_dvfs_actuator_if;
  logic [2:0] vreg_code;
  logic       vreg_req;
  logic       vreg_ack;
  logic [2:0] freq_code;
  logic       pll_lock;

  modport master (
    output vreg_code,
    output vreg_req,
    output freq_code,
    input  vreg_ack,
    input  pll_lock
  );

  modport slave (
    input  vreg_code,
    input  vreg_req,
    input  freq_code,
    output vreg_ack,
    output pll_lock
  );
endinterface

// File: rtl/cevero_dvfs_actuator.sv
// DVFS actuator: applies requested voltage/frequency codes in a safe order.
// Voltage rises before frequency; frequency falls before voltage. Voltage moves
// one code per regulator handshake, each followed by a fixed settle interval.
// A regulator that never acknowledges raises a sticky fault.
module cevero_dvfs_actuator #(
  parameter int unsigned VSettleCycles = 16,
  parameter int unsigned FSettleCycles = 4,
  parameter int unsigned AckTimeout    = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [2:0]                    def_voltage_i,
  input  logic [2:0]                    def_freq_i,
  input  logic [2:0]                    target_voltage_i,
  input  logic [2:0]                    target_freq_i,
  cevero_dvfs_actuator_if.master        bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fault_o
);

  localparam int unsigned CntMax0 = (VSettleCycles > AckTimeout) ? VSettleCycles : AckTimeout;
  localparam int unsigned CntMax  = (CntMax0 > FSettleCycles) ? CntMax0 : FSettleCycles;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    IDLE,
    VREQ,
    VSETTLE,
    FSET,
    FLOCK,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        vcode_q, vcode_d;
  logic [2:0]        last_v_q, last_v_d;
  logic [2:0]        fcode_q, fcode_d;
  logic [2:0]        tgt_v_q, tgt_v_d;
  logic [2:0]        tgt_f_q, tgt_f_d;
  logic              dir_up_q, dir_up_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              enter_vreq;

  // Next-state and next-output logic; every output is computed here and
  // registered below, so "entering VREQ" is folded into one shared block.
  always_comb begin
    state_d    = state_q;
    vcode_d    = vcode_q;
    last_v_d   = last_v_q;
    fcode_d    = fcode_q;
    tgt_v_d    = tgt_v_q;
    tgt_f_d    = tgt_f_q;
    dir_up_d   = dir_up_q;
    req_d      = req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    enter_vreq = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fault_q && ((target_voltage_i != vcode_q) || (target_freq_i != fcode_q))) begin
          tgt_v_d  = target_voltage_i;
          tgt_f_d  = target_freq_i;
          busy_d   = 1'b1;
          dir_up_d = (target_voltage_i > vcode_q);
          if (dir_up_d || (target_freq_i == fcode_q)) begin
            enter_vreq = 1'b1;
          end else begin
            state_d = FSET;
          end
        end
      end
      VREQ: begin
        if (bus.vreg_ack) begin
          req_d    = 1'b0;
          last_v_d = vcode_q;
          state_d  = VSETTLE;
          cnt_d    = '0;
        end else if (cnt_q == CntW'(AckTimeout - 1)) begin
          req_d   = 1'b0;
          vcode_d = last_v_q;
          fault_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      VSETTLE: begin
        if (cnt_q == CntW'(VSettleCycles - 1)) begin
          if (vcode_q != tgt_v_q) begin
            enter_vreq = 1'b1;
          end else if (dir_up_q && (tgt_f_q != fcode_q)) begin
            state_d = FSET;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FSET: begin
        fcode_d = tgt_f_q;
        state_d = FLOCK;
        cnt_d   = '0;
      end
      FLOCK: begin
        if ((cnt_q >= CntW'(FSettleCycles)) && bus.pll_lock) begin
          if (!dir_up_q && (vcode_q != tgt_v_q)) begin
            enter_vreq = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (cnt_q < CntW'(FSettleCycles)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_vreq) begin
      state_d = VREQ;
      vcode_d = dir_up_d ? (vcode_q + 3'd1) : (vcode_q - 3'd1);
      req_d   = 1'b1;
      cnt_d   = '0;
    end
  end

  // State and registered outputs; reset loads the default operating point.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      vcode_q  <= def_voltage_i;
      last_v_q <= def_voltage_i;
      fcode_q  <= def_freq_i;
      tgt_v_q  <= def_voltage_i;
      tgt_f_q  <= def_freq_i;
      dir_up_q <= 1'b0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      vcode_q  <= vcode_d;
      last_v_q <= last_v_d;
      fcode_q  <= fcode_d;
      tgt_v_q  <= tgt_v_d;
      tgt_f_q  <= tgt_f_d;
      dir_up_q <= dir_up_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.vreg_code = vcode_q;
  assign bus.vreg_req  = req_q;
  assign bus.freq_code = fcode_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_cevero_dvfs_actuator.sv
// Testbench for cevero_dvfs_actuator: directed and random transitions checked
// against an event-order/timing model of the voltage/frequency sequencing.
module tb_cevero_dvfs_actuator;

  localparam int VS = 16;
  localparam int FS = 4;
  localparam int AT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] def_voltage = 3'd2;
  logic [2:0] def_freq = 3'd3;
  logic [2:0] target_voltage = 3'd2;
  logic [2:0] target_freq = 3'd3;
  logic       busy, done, fault;

  cevero_dvfs_actuator_if bus ();

  cevero_dvfs_actuator #(
    .VSettleCycles(VS),
    .FSettleCycles(FS),
    .AckTimeout(AT)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .def_voltage_i(def_voltage),
    .def_freq_i(def_freq),
    .target_voltage_i(target_voltage),
    .target_freq_i(target_freq),
    .bus(bus),
    .busy_o(busy),
    .done_o(done),
    .fault_o(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int cur_v, cur_f;
  int ek[16];
  int evv[16];
  int nev, idx, n, exp_t, ack_at, lock_at, lat_a, lat_l, last_step;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic push_ev(input int k, input int v);
    ek[nev]  = k;
    evv[nev] = v;
    nev++;
  endtask

  // Observed event k (0 voltage step, 1 frequency change, 2 done) with value val.
  task automatic on_event(input int k, input int val);
    int x;
    bit next_is_step;
    if (idx >= nev) begin
      check("extra_event_kind", 32'(k), 32'hFF);
      return;
    end
    check("event_kind", 32'(k), 32'(ek[idx]));
    check("event_value", 32'(val), 32'(evv[idx]));
    check("event_cycle", 32'(n), 32'(exp_t));
    next_is_step = (idx + 1 < nev) && (ek[idx+1] == 0);
    if (ek[idx] == 0) begin
      last_step = evv[idx];
      ack_at    = n + lat_a;
      exp_t     = ack_at + VS + (next_is_step ? 0 : 1);
    end else if (ek[idx] == 1) begin
      lock_at = n + lat_l;
      x       = (n + FS + 1 > lock_at) ? n + FS + 1 : lock_at;
      exp_t   = x + (next_is_step ? 0 : 1);
    end
    idx++;
  endtask

  // Request (tv,tf) and follow the transition to completion. Optionally
  // changes target voltage to chg_v at relative cycle chg_at.
  task automatic run(input int tv, input int tf, input int la, input int ll,
                     input int chg_at, input int chg_v);
    logic       prev_req;
    logic [2:0] prev_f;
    nev = 0; idx = 0; n = 0; ack_at = 0; lock_at = 0;
    lat_a = la; lat_l = ll; last_step = cur_v;
    if (tv > cur_v) begin
      for (int v = cur_v + 1; v <= tv; v++) push_ev(0, v);
      if (tf != cur_f) push_ev(1, tf);
    end else begin
      if (tf != cur_f) push_ev(1, tf);
      for (int v = cur_v - 1; v >= tv; v--) push_ev(0, v);
    end
    if (nev > 0) push_ev(2, 0);
    exp_t = (nev > 0 && ek[0] == 1) ? 2 : 1;
    target_voltage = 3'(tv);
    target_freq    = 3'(tf);
    prev_req = bus.vreg_req;
    prev_f   = bus.freq_code;
    if (nev == 0) begin
      repeat (3) begin
        @(posedge clk); #1; n++;
        check("noop_busy", 32'(busy), 32'd0);
        check("noop_req", 32'(bus.vreg_req), 32'd0);
      end
      return;
    end
    while (idx < nev && n < 600) begin
      @(posedge clk); #1; n++;
      if (chg_at == n) target_voltage = 3'(chg_v);
      if (bus.vreg_req && !prev_req) on_event(0, int'(bus.vreg_code));
      if (bus.freq_code != prev_f) on_event(1, int'(bus.freq_code));
      if (done) on_event(2, 0);
      if (n == ack_at) check("req_drop_after_ack", 32'(bus.vreg_req), 32'd0);
      if (bus.vreg_req) check("code_stable_in_req", 32'(bus.vreg_code), 32'(last_step));
      check("busy", 32'(busy), 32'(idx < nev));
      prev_req = bus.vreg_req;
      prev_f   = bus.freq_code;
      bus.vreg_ack = (n + 1 == ack_at);
      bus.pll_lock = (lock_at != 0) && (n + 1 >= lock_at);
    end
    if (idx < nev) check("transition_timeout", 32'(idx), 32'(nev));
    bus.vreg_ack = 1'b0;
    bus.pll_lock = 1'b0;
    check("final_vcode", 32'(bus.vreg_code), 32'(tv));
    check("final_fcode", 32'(bus.freq_code), 32'(tf));
    check("final_fault", 32'(fault), 32'd0);
    cur_v = tv;
    cur_f = tf;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vcode"}, 32'(bus.vreg_code), 32'(def_voltage));
    check({tag, "_fcode"}, 32'(bus.freq_code), 32'(def_freq));
    check({tag, "_req"}, 32'(bus.vreg_req), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  task automatic do_reset();
    target_voltage = def_voltage;
    target_freq    = def_freq;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cur_v = int'(def_voltage);
    cur_f = int'(def_freq);
  endtask

  initial begin
    bus.vreg_ack = 1'b0;
    bus.pll_lock = 1'b0;
    n = 0;

    // reset state
    do_reset();

    // up-scale, down-scale, frequency only
    run(4, 5, 2, 3, 0, 0);
    run(3, 2, 2, 6, 0, 0);
    run(3, 6, 1, 1, 0, 0);

    // target voltage changes 4->5 mid-transition (during settle)
    run(4, 6, 2, 2, 10, 5);
    run(5, 6, 3, 2, 0, 0);

    // random transitions
    for (int i = 0; i < 30; i++) begin
      run(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(1, 4)), int'($urandom_range(1, 8)), 0, 0);
    end

    // reset while a request is outstanding
    do_reset();
    target_voltage = 3'd3;
    @(posedge clk); #1;
    check("vreq_req_before_reset", 32'(bus.vreg_req), 32'd1);
    check("vreq_code_before_reset", 32'(bus.vreg_code), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    target_voltage = def_voltage;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_reset_req", 32'(bus.vreg_req), 32'd0);
      check("post_reset_done", 32'(done), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_fault", 32'(fault), 32'd0);
    end

    // regulator timeout: 2 -> 3 with no acknowledge
    target_voltage = 3'd3;
    target_freq    = 3'd3;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("to_req_rise", 32'(bus.vreg_req), 32'd1);
      if (c == AT) begin
        check("to_req_held", 32'(bus.vreg_req), 32'd1);
        check("to_code_held", 32'(bus.vreg_code), 32'd3);
        check("to_fault_low", 32'(fault), 32'd0);
      end
      if (c == AT + 1) begin
        check("to_req_drop", 32'(bus.vreg_req), 32'd0);
        check("to_code_revert", 32'(bus.vreg_code), 32'd2);
        check("to_fault", 32'(fault), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_done", 32'(done), 32'd0);
      end
    end
    target_voltage = 3'd5;
    target_freq    = 3'd1;
    repeat (20) begin
      @(posedge clk); #1;
      check("fault_blocks_req", 32'(bus.vreg_req), 32'd0);
      check("fault_blocks_busy", 32'(busy), 32'd0);
    end
    check("fault_vcode", 32'(bus.vreg_code), 32'd2);
    check("fault_fcode", 32'(bus.freq_code), 32'd3);
    check("fault_sticky", 32'(fault), 32'd1);

    // reset clears the fault
    do_reset();
    @(posedge clk); #1;
    check("fault_cleared", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cevero_dvfs_actuator.md
# cevero_dvfs_actuator

Downstream stage of the DVFS controller. Consumes the controller's requested voltage and frequency codes and applies them to the voltage regulator and the PLL in a safe order. Voltage goes up before frequency rises; frequency goes down before voltage falls. Voltage moves one code per regulator handshake, and each step is followed by a settle interval. The block reports busy, completion and a sticky regulator-timeout fault.

## Interface
- VSettleCycles, 16: cycles waited after each acknowledged voltage step.
- FSettleCycles, 4: minimum cycles waited after a frequency change before PLL lock is accepted.
- AckTimeout, 64: maximum cycles vreg_req_o may stay high without vreg_ack_i.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous and active-low.
- def_voltage_i  in  3  voltage code loaded into vreg_code_o at reset.
- def_freq_i  in  3  frequency code loaded into freq_code_o at reset.
- target_voltage_i  in  3  requested voltage code (DVFS controller set_voltage_o).
- target_freq_i  in  3  requested frequency code (DVFS controller set_freq_o).
- vreg_code_o  out  3  voltage code driven to the regulator.
- vreg_req_o  out  1  regulator request; vreg_code_o is stable while it is high.
- vreg_ack_i  in  1  regulator acknowledge.
- freq_code_o  out  3  frequency code driven to the PLL.
- pll_lock_i  in  1  PLL locked.
- busy_o  out  1  a transition is in progress.
- done_o  out  1  one-cycle pulse when a transition completes.
- fault_o  out  1  sticky regulator-timeout fault.

## Operation
- Reset values: vreg_code_o=def_voltage_i, freq_code_o=def_freq_i; vreg_req_o, busy_o, done_o, fault_o all 0; state IDLE; all counters 0; last-acked voltage = def_voltage_i.
- States: IDLE, VREQ, VSETTLE, FSET, FLOCK, DONE.
- IDLE (fault_o=0): if target_voltage_i≠vreg_code_o or target_freq_i≠freq_code_o:
  - latch both targets into tgt_v/tgt_f and set busy_o.
  - set dir_up = (tgt_v > vreg_code_o).
  - next state: VREQ if dir_up; else FSET if tgt_f≠freq_code_o; else VREQ.
- Targets are sampled only in IDLE. Input changes during a transition are ignored until the block returns to IDLE, where they are re-evaluated.
- Entering VREQ:
  - vreg_code_o becomes vreg_code_o+1 (dir_up) or vreg_code_o−1, and vreg_req_o=1.
  - The timeout counter clears.
  - Codes are unsigned 3-bit. Steps never go past tgt_v, so no wrap is possible.
- VREQ:
  - vreg_ack_i=1 sampled: next cycle vreg_req_o=0, last-acked voltage=vreg_code_o, state VSETTLE, settle counter=0.
  - Timeout counter reaches AckTimeout−1 with no ack: vreg_req_o=0, vreg_code_o reverts to last-acked, fault_o=1, busy_o=0, state IDLE, no done_o.
- VSETTLE: stays exactly VSettleCycles cycles, then:
  - VREQ if vreg_code_o≠tgt_v;
  - else FSET if dir_up and tgt_f≠freq_code_o;
  - else DONE.
- FSET (1 cycle): freq_code_o<=tgt_f; next state FLOCK with counter=0.
- FLOCK: exits once counter≥FSettleCycles and pll_lock_i=1, then:
  - VREQ if !dir_up and vreg_code_o≠tgt_v;
  - else DONE.
  - No timeout in FLOCK.
- DONE (1 cycle): done_o=1, busy_o=0 on the following edge; next state IDLE.
- fault_o=1 blocks all new transitions until reset. freq_code_o is left unchanged by a fault.
- vreg_ack_i outside VREQ is ignored.

## Timing
- All outputs are registered. Decision edge = the edge at which IDLE detects a difference.
- At the decision edge, busy_o=1. If the path starts in VREQ, vreg_req_o=1 and the new vreg_code_o are visible in the same cycle.
- Ack sampled at edge k: vreg_req_o=0 from edge k; the first VSETTLE cycle follows. Each voltage step costs (ack latency + VSettleCycles + 1) cycles.
- Frequency change: freq_code_o updates one cycle after entering FSET. FLOCK lasts at least FSettleCycles cycles.
- done_o goes high in the cycle after the last settle completes, for exactly one cycle. busy_o falls in the same cycle done_o rises.
- Reset asserted mid-transition: all outputs return to reset values immediately (asynchronous). No req, done or fault glitch follows deassertion.

## Test plan
- Up-scale: reset v=2, f=3; target v=4, f=5; ack 2 cycles after each req.
  - Two VREQ handshakes, vreg_code_o 3 then 4, each followed by 16 settle cycles.
  - Only then freq_code_o=5; pll_lock_i high → one done_o pulse.
- Down-scale: from v=4, f=5, target v=3, f=2.
  - freq_code_o=2 first; wait ≥4 cycles plus lock.
  - Then one handshake to vreg_code_o=3, 16 settle cycles, then done_o.
- Frequency only: targets differ only in f (3→6).
  - No vreg_req_o activity; freq_code_o=6, done_o after lock.
- Timeout: ack held low at v=2→3.
  - After 64 cycles: vreg_req_o=0, vreg_code_o=2, fault_o=1.
  - A later target change produces no activity until reset.
- Target change mid-transition: target v changes 4→5 during VSETTLE.
  - Transition completes at 4 with done_o.
  - Block re-enters VREQ to reach 5 on the next IDLE cycle.
- Reset during VREQ with req high: outputs immediately return to the def_* values, req=0, busy=0.
